// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//
// Execute-stage ALU. Takes the 5-bit ALU control code and the sign bit from the
// control decoder, operates on two DATA_W-bit operands and returns a registered
// result over a valid/ready handshake.
//
// Logic ops, add/sub, SLT, illegal codes and zero-amount shifts complete on the
// accept edge. Non-zero shifts run iteratively, SHIFT_STEP bits per cycle, and
// hold in_ready low until the result is loaded.
//
// Build option:
//   FAST_SHIFT_EN  single-cycle barrel shifter, no SHIFT state, SHIFT_STEP unused
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   in_valid   operation request
//   in_ready   unit can accept a request this cycle
//   alu_ctrl   0=ADD 1=SUB 2=AND 3=OR 4=XOR 5=NOR 6=SLL 7=SRL 8=SRA 9=SLT
//   sign       1 = signed compare / overflow semantics
//   op_a       operand A (rs)
//   op_b       operand B (rt/imm), source operand for shifts
//   shamt      shift amount
//   out_valid  result registers hold an unconsumed result
//   out_ready  downstream accepts the result
//   result     operation result
//   zero       result == 0
//   overflow   signed ADD/SUB overflow (only when sign=1)
//   illegal    alu_ctrl > 9
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | ready to accept a new operation
// SHIFT | iterative shift in progress, in_ready held low
// -----------------------------------------------------------------------------
module alu_exec_unit #(
   parameter int DATA_W     = 32,
   parameter int SHIFT_STEP = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        alu_ctrl,
   input  logic              sign,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   input  logic [4:0]        shamt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              overflow,
   output logic              illegal
);

   localparam int MSB = DATA_W - 1;

   localparam logic [4:0] OP_ADD = 5'd0;
   localparam logic [4:0] OP_SUB = 5'd1;
   localparam logic [4:0] OP_AND = 5'd2;
   localparam logic [4:0] OP_OR  = 5'd3;
   localparam logic [4:0] OP_XOR = 5'd4;
   localparam logic [4:0] OP_NOR = 5'd5;
   localparam logic [4:0] OP_SLL = 5'd6;
   localparam logic [4:0] OP_SRL = 5'd7;
   localparam logic [4:0] OP_SRA = 5'd8;
   localparam logic [4:0] OP_SLT = 5'd9;

   logic              out_free;
   logic              accept;
   logic              is_shift;
   logic              start_iter;
   logic [DATA_W-1:0] sum;
   logic [DATA_W-1:0] diff;
   logic              lt;
   logic [DATA_W-1:0] nx_res;
   logic              nx_ov;
   logic              nx_ill;

   // The output register can take a new value when empty or being drained
   // on this same edge.
   assign out_free = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign is_shift = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) ||
                     (alu_ctrl == OP_SRA);
   assign sum      = op_a + op_b;
   assign diff     = op_a - op_b;

   // Single-cycle result for everything that completes on the accept edge.
   always_comb begin
      nx_res = '0;
      nx_ov  = 1'b0;
      nx_ill = 1'b0;
      lt     = sign ? ($signed(op_a) < $signed(op_b)) : (op_a < op_b);
      case (alu_ctrl)
         OP_ADD: begin
            nx_res = sum;
            nx_ov  = sign && (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
         end
         OP_SUB: begin
            nx_res = diff;
            nx_ov  = sign && (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
         end
         OP_AND: nx_res = op_a & op_b;
         OP_OR:  nx_res = op_a | op_b;
         OP_XOR: nx_res = op_a ^ op_b;
         OP_NOR: nx_res = ~(op_a | op_b);
`ifdef FAST_SHIFT_EN
         OP_SLL: nx_res = op_b << shamt;
         OP_SRL: nx_res = op_b >> shamt;
         OP_SRA: nx_res = $signed(op_b) >>> shamt;
`else
         // Only reaches the output this way when shamt == 0; non-zero
         // amounts go through the SHIFT state.
         OP_SLL, OP_SRL, OP_SRA: nx_res = op_b;
`endif
         OP_SLT: nx_res = {{(DATA_W-1){1'b0}}, lt};
         default: nx_ill = 1'b1;
      endcase
   end

`ifndef FAST_SHIFT_EN
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam logic [1:0] KIND_SLL = 2'd0;
   localparam logic [1:0] KIND_SRL = 2'd1;
   localparam logic [1:0] KIND_SRA = 2'd2;
   localparam logic [4:0] STEP5    = 5'(SHIFT_STEP);

   state_t            state;
   state_t            state_nx;
   logic [DATA_W-1:0] sh_val;
   logic [DATA_W-1:0] sh_val_nx;
   logic [4:0]        sh_rem;
   logic [4:0]        sh_rem_nx;
   logic [4:0]        sh_amt;
   logic [1:0]        sh_kind;
   logic              shift_done;

   assign start_iter = is_shift && (shamt != 5'd0);
   assign in_ready   = reset_n && (state == IDLE) && out_free;

   // Last step may be shorter than SHIFT_STEP.
   assign sh_amt    = (sh_rem < STEP5) ? sh_rem : STEP5;
   assign sh_rem_nx = sh_rem - sh_amt;

   always_comb begin
      sh_val_nx = sh_val;
      case (sh_kind)
         KIND_SLL: sh_val_nx = sh_val << sh_amt;
         KIND_SRL: sh_val_nx = sh_val >> sh_amt;
         KIND_SRA: sh_val_nx = $signed(sh_val) >>> sh_amt;
         default:  sh_val_nx = sh_val;
      endcase
   end

   // Once the amount is used up the shifter parks (sh_amt = 0) until the
   // output register is free.
   assign shift_done = (state == SHIFT) && (sh_rem_nx == 5'd0) && out_free;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept && start_iter) state_nx = SHIFT;
         SHIFT:   if (shift_done)           state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sh_val  <= '0;
         sh_rem  <= '0;
         sh_kind <= KIND_SLL;
      end else if (accept && start_iter) begin
         sh_val <= op_b;
         sh_rem <= shamt;
         case (alu_ctrl)
            OP_SRL:  sh_kind <= KIND_SRL;
            OP_SRA:  sh_kind <= KIND_SRA;
            default: sh_kind <= KIND_SLL;
         endcase
      end else if (state == SHIFT) begin
         sh_val <= sh_val_nx;
         sh_rem <= sh_rem_nx;
      end
   end
`else
   assign start_iter = 1'b0;
   assign in_ready   = reset_n && out_free;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b0;
         overflow  <= 1'b0;
         illegal   <= 1'b0;
      end else if (accept && !start_iter) begin
         out_valid <= 1'b1;
         result    <= nx_res;
         zero      <= (nx_res == '0);
         overflow  <= nx_ov;
         illegal   <= nx_ill;
      end
`ifndef FAST_SHIFT_EN
      else if (shift_done) begin
         out_valid <= 1'b1;
         result    <= sh_val_nx;
         zero      <= (sh_val_nx == '0);
         overflow  <= 1'b0;
         illegal   <= 1'b0;
      end
`endif
      else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
